// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : display_arbiter
//  Purpose  : Shares the 4-digit HEX display and LEDR[3:0] among four
//             requesters (level, timer, fail banner, pattern playback).
//             Fixed priority with req[3] highest, a minimum ownership hold
//             counted in tick strobes, and per-requester blinking.
//  Ports    : CLOCK_50   - system clock
//             reset      - synchronous, active-high reset
//             tick       - single-cycle time-base strobe
//             req[3:0]   - level requests, index 3 has highest priority
//             digits_in  - requester i digits at [16i+15:16i]
//             leds_in    - requester i LED pattern at [4i+3:4i]
//             blink[3:0] - per-requester blink enable
//             grant      - one-hot owner, 0 when idle (registered)
//             seg_digits - four nibbles to the segment decoders (registered)
//             leds       - LEDR[3:0] (registered)
//             busy       - high while grant != 0 (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int         MIN_HOLD   = 2,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  req,
    input  logic [63:0] digits_in,
    input  logic [15:0] leds_in,
    input  logic [3:0]  blink,
    output logic [3:0]  grant,
    output logic [15:0] seg_digits,
    output logic [3:0]  leds,
    output logic        busy
);

    localparam int c_hold_w = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(MIN_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_zero = '0;
    localparam logic [15:0]         c_blank     = {4{BLANK_CODE}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hold = 2'd1;
    localparam logic [1:0] c_st_open = 2'd2;
    // A freshly granted owner skips HOLD entirely when no hold is configured.
    localparam logic [1:0] c_st_after_grant = (MIN_HOLD > 0) ? c_st_hold : c_st_open;

    logic [1:0]          r_state;
    logic [3:0]          r_grant;
    logic [c_hold_w-1:0] r_hold;
    logic                r_phase;
    logic [15:0]         r_seg;
    logic [3:0]          r_leds;
    logic                r_busy;

    logic [1:0]          w_next_state;
    logic [3:0]          w_next_grant;
    logic [c_hold_w-1:0] w_next_hold;
    logic                w_change;
    logic                w_next_phase;
    logic [3:0]          w_higher_req;
    logic                w_owner_blink;
    logic [15:0]         w_sel_digits;
    logic [3:0]          w_sel_leds;
    logic [15:0]         w_next_seg;
    logic [3:0]          w_next_leds;

    // One-hot of the highest set bit.
    function automatic logic [3:0] f_top(input logic [3:0] r);
        if (r[3])      return 4'b1000;
        else if (r[2]) return 4'b0100;
        else if (r[1]) return 4'b0010;
        else if (r[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    // ------------------------------------------------------------------
    // State register (also carries the registered output path)
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_grant <= 4'b0000;
            r_hold  <= c_hold_zero;
            r_phase <= 1'b0;
            r_seg   <= c_blank;
            r_leds  <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_hold  <= w_next_hold;
            r_phase <= w_next_phase;
            r_seg   <= w_next_seg;
            r_leds  <= w_next_leds;
            r_busy  <= |w_next_grant;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: ownership, hold counter, blink phase
    // ------------------------------------------------------------------
    always_comb begin
        // Requests strictly above the current owner: clear the owner bit and
        // every bit below it.
        w_higher_req = req & ~(r_grant | (r_grant - 4'd1));

        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_hold  = r_hold;
        w_change     = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (|req) begin
                    w_next_grant = f_top(req);
                    w_next_hold  = c_hold_load;
                    w_next_state = c_st_after_grant;
                    w_change     = 1'b1;
                end
            end
            c_st_hold: begin
                // Owner is locked; requests are ignored until the hold expires.
                if (tick) begin
                    if (r_hold <= c_hold_one) begin
                        w_next_hold  = c_hold_zero;
                        w_next_state = c_st_open;
                    end else begin
                        w_next_hold = r_hold - c_hold_one;
                    end
                end
            end
            c_st_open: begin
                if (|w_higher_req) begin
                    w_next_grant = f_top(w_higher_req);
                    w_next_hold  = c_hold_load;
                    w_next_state = c_st_after_grant;
                    w_change     = 1'b1;
                end else if ((req & r_grant) == 4'b0000) begin
                    w_change = 1'b1;
                    if (|req) begin
                        w_next_grant = f_top(req);
                        w_next_hold  = c_hold_load;
                        w_next_state = c_st_after_grant;
                    end else begin
                        w_next_grant = 4'b0000;
                        w_next_hold  = c_hold_zero;
                        w_next_state = c_st_idle;
                    end
                end
            end
            default: begin
                w_next_grant = 4'b0000;
                w_next_hold  = c_hold_zero;
                w_next_state = c_st_idle;
                w_change     = 1'b1;
            end
        endcase

        // Blink phase restarts visible on every ownership change and only
        // runs while the current owner has blinking enabled.
        w_owner_blink = |(blink & r_grant);
        w_next_phase  = 1'b0;
        if (!w_change && w_owner_blink) begin
            w_next_phase = tick ? ~r_phase : r_phase;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: select the owner's slice, blank when idle or blinked off
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_digits = 16'h0000;
        w_sel_leds   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_sel_digits = w_sel_digits | (digits_in[16*i +: 16] & {16{r_grant[i]}});
            w_sel_leds   = w_sel_leds   | (leds_in[4*i +: 4]     & {4{r_grant[i]}});
        end

        if ((r_grant == 4'b0000) || r_phase) begin
            w_next_seg  = c_blank;
            w_next_leds = 4'b0000;
        end else begin
            w_next_seg  = w_sel_digits;
            w_next_leds = w_sel_leds;
        end
    end

    assign grant      = r_grant;
    assign seg_digits = r_seg;
    assign leds       = r_leds;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_arbiter
//  Purpose  : Self-checking bench for display_arbiter. A cycle-level
//             reference model predicts the registered outputs; predictions
//             are queued before each clock edge and compared after it.
//             Directed checks pin the key scenarios to literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int c_min_hold = 2;

    logic        CLOCK_50;
    logic        reset;
    logic        tick;
    logic [3:0]  req;
    logic [63:0] digits_in;
    logic [15:0] leds_in;
    logic [3:0]  blink;
    logic [3:0]  grant;
    logic [15:0] seg_digits;
    logic [3:0]  leds;
    logic        busy;

    display_arbiter #(
        .MIN_HOLD   (c_min_hold),
        .BLANK_CODE (4'hF)
    ) u_dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .tick       (tick),
        .req        (req),
        .digits_in  (digits_in),
        .leds_in    (leds_in),
        .blink      (blink),
        .grant      (grant),
        .seg_digits (seg_digits),
        .leds       (leds),
        .busy       (busy)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        logic [3:0]  grant;
        logic [15:0] seg;
        logic [3:0]  leds;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: owner index (-1 = none), hold count, state
    // (0 idle, 1 hold, 2 open), blink phase.
    int m_owner = -1;
    int m_hold  = 0;
    int m_st    = 0;
    bit m_phase = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Highest index >= lo with r set, or -1.
    function automatic int hi_from(input logic [3:0] r, input int lo);
        for (int i = 3; i >= 0; i--) begin
            if (i >= lo && r[i]) return i;
        end
        return -1;
    endfunction

    // Predict the outputs after the coming edge and advance the model.
    task automatic model_step(output exp_t e);
        int n_owner;
        bit chg;
        if (reset) begin
            m_owner = -1; m_hold = 0; m_st = 0; m_phase = 1'b0;
            e.grant = 4'b0000; e.seg = 16'hFFFF; e.leds = 4'b0000; e.busy = 1'b0;
            return;
        end
        if (m_owner < 0 || m_phase) begin
            e.seg  = 16'hFFFF;
            e.leds = 4'b0000;
        end else begin
            e.seg  = digits_in[16*m_owner +: 16];
            e.leds = leds_in[4*m_owner +: 4];
        end
        n_owner = m_owner;
        chg     = 1'b0;
        if (m_st == 0) begin
            if (req != 4'b0000) begin n_owner = hi_from(req, 0); chg = 1'b1; end
        end else if (m_st == 1) begin
            if (tick) begin
                if (m_hold > 0) m_hold--;
                if (m_hold == 0) m_st = 2;
            end
        end else begin
            if (hi_from(req, m_owner + 1) >= 0) begin
                n_owner = hi_from(req, m_owner + 1); chg = 1'b1;
            end else if (!req[m_owner]) begin
                n_owner = hi_from(req, 0); chg = 1'b1;
            end
        end
        if (chg) begin
            m_phase = 1'b0;
            if (n_owner >= 0) begin
                m_hold = c_min_hold;
                m_st   = (c_min_hold > 0) ? 1 : 2;
            end else begin
                m_hold = 0;
                m_st   = 0;
            end
        end else if (m_owner >= 0 && blink[m_owner]) begin
            if (tick) m_phase = ~m_phase;
        end else begin
            m_phase = 1'b0;
        end
        m_owner = n_owner;
        e.grant = (n_owner >= 0) ? (4'b0001 << n_owner) : 4'b0000;
        e.busy  = (n_owner >= 0);
    endtask

    task automatic cycle();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        e = sb.pop_front();
        check("sb_grant", {28'd0, grant},  {28'd0, e.grant});
        check("sb_seg",   {16'd0, seg_digits}, {16'd0, e.seg});
        check("sb_leds",  {28'd0, leds},   {28'd0, e.leds});
        check("sb_busy",  {31'd0, busy},   {31'd0, e.busy});
    endtask

    task automatic tick_cycle();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; req = 4'b0000;
        digits_in = 64'd0; leds_in = 16'd0; blink = 4'b0000;
        cycle();
        cycle();
        check("rst_grant", {28'd0, grant}, 32'h0);
        check("rst_seg",   {16'd0, seg_digits}, 32'hFFFF);
        check("rst_leds",  {28'd0, leds}, 32'h0);
        check("rst_busy",  {31'd0, busy}, 32'h0);

        // 1: single requester 0
        reset = 1'b0;
        digits_in[15:0] = 16'h00D1; leds_in[3:0] = 4'h1; req = 4'b0001;
        cycle();
        check("t1_grant", {28'd0, grant}, 32'h1);
        cycle();
        check("t1_seg",  {16'd0, seg_digits}, 32'h00D1);
        check("t1_busy", {31'd0, busy}, 32'h1);
        check("t1_leds", {28'd0, leds}, 32'h1);

        // 2: higher request waits out the hold
        digits_in[63:48] = 16'hABCD; leds_in[15:12] = 4'hA; req = 4'b1001;
        cycle(); cycle(); cycle();
        check("t2_wait0", {28'd0, grant}, 32'h1);
        tick_cycle();
        cycle();
        check("t2_wait1", {28'd0, grant}, 32'h1);
        tick_cycle();
        check("t2_wait2", {28'd0, grant}, 32'h1);
        cycle();
        check("t2_grant", {28'd0, grant}, 32'h8);
        cycle();
        check("t2_seg",  {16'd0, seg_digits}, 32'hABCD);
        check("t2_leds", {28'd0, leds}, 32'hA);

        // 3: lower request cannot preempt; owner drop hands over
        tick_cycle(); cycle(); tick_cycle();
        req = 4'b1011;
        cycle(); cycle();
        check("t3_keep", {28'd0, grant}, 32'h8);
        req = 4'b0011;
        cycle();
        check("t3_grant", {28'd0, grant}, 32'h2);

        // 4: blink on owner 1
        digits_in[31:16] = 16'h1234; leds_in[7:4] = 4'h5; blink = 4'b0010;
        cycle();
        check("t4_vis0", {16'd0, seg_digits}, 32'h1234);
        tick_cycle();
        cycle();
        check("t4_off_seg",  {16'd0, seg_digits}, 32'hFFFF);
        check("t4_off_leds", {28'd0, leds}, 32'h0);
        tick_cycle();
        cycle();
        check("t4_on_seg",  {16'd0, seg_digits}, 32'h1234);
        check("t4_on_leds", {28'd0, leds}, 32'h5);

        // 5: everything drops in OPEN
        blink = 4'b0000; req = 4'b0000;
        cycle();
        check("t5_grant", {28'd0, grant}, 32'h0);
        check("t5_busy",  {31'd0, busy}, 32'h0);
        cycle();
        check("t5_seg",  {16'd0, seg_digits}, 32'hFFFF);
        check("t5_leds", {28'd0, leds}, 32'h0);

        // 6: reset mid-hold with a coincident tick
        req = 4'b0100;
        cycle();
        check("t6_grant", {28'd0, grant}, 32'h4);
        cycle();
        reset = 1'b1; tick = 1'b1;
        cycle();
        check("t6_rgrant", {28'd0, grant}, 32'h0);
        check("t6_rseg",   {16'd0, seg_digits}, 32'hFFFF);
        check("t6_rleds",  {28'd0, leds}, 32'h0);
        check("t6_rbusy",  {31'd0, busy}, 32'h0);
        reset = 1'b0; tick = 1'b0; req = 4'b0000;
        cycle();
        check("t6_idle", {28'd0, grant}, 32'h0);

        // Random traffic checked only by the scoreboard model
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 80) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blink = 4'($urandom_range(0, 15));
            digits_in = {$urandom, $urandom};
            leds_in   = 16'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
